// File: rtl/des_sbox_scheduler_pkg.sv
// Shared DES S-layer definitions: widths, scheduler FSM encoding, S-box tables
// and chunk/lookup helpers used by the scheduler and the shared S-box bank.
package des_sbox_scheduler_pkg;

  localparam int SBOX_CNT   = 8;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int DES_HALF_W = 32;
  localparam int DES_EXP_W  = 48;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DONE   = 2'd2
  } sched_state_e;

  // Chunk 0 is the S1 input (bits 47:42), chunk 7 the S8 input (bits 5:0).
  function automatic logic [SBOX_IN_W-1:0] chunk_at(input logic [DES_EXP_W-1:0] data,
                                                   input logic [2:0] idx);
    logic [SBOX_IN_W-1:0] c;
    case (idx)
      3'd0:    c = data[47:42];
      3'd1:    c = data[41:36];
      3'd2:    c = data[35:30];
      3'd3:    c = data[29:24];
      3'd4:    c = data[23:18];
      3'd5:    c = data[17:12];
      3'd6:    c = data[11:6];
      3'd7:    c = data[5:0];
      default: c = 6'd0;
    endcase
    return c;
  endfunction

  // Tables hold rows 0..3 left to right, 16 nibbles per row; row = {b5,b0}, col = b4:1.
  function automatic logic [SBOX_OUT_W-1:0] sbox_lookup(input logic [2:0] sel,
                                                       input logic [SBOX_IN_W-1:0] chunk);
    logic [255:0] tbl;
    logic [7:0]   pos;
    case (sel)
      3'd0:    tbl = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
      3'd1:    tbl = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
      3'd2:    tbl = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
      3'd3:    tbl = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
      3'd4:    tbl = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
      3'd5:    tbl = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
      3'd6:    tbl = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
      3'd7:    tbl = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
      default: tbl = 256'h0;
    endcase
    pos = 8'd255 - {chunk[5], chunk[0], chunk[4:1], 2'b00};
    return tbl[pos -: 4];
  endfunction

endpackage

// File: rtl/des_sbox_bank.sv
// Shared combinational DES S-box bank: S1..S8 behind a 3-bit select.
// Lives at round level so several requesters can share it.
module des_sbox_bank
  import des_sbox_scheduler_pkg::*;
(
  input  logic [2:0]            sel,
  input  logic [SBOX_IN_W-1:0]  chunk,
  output logic [SBOX_OUT_W-1:0] result
);

  // Table lookup for the selected S-box
  always_comb begin
    result = sbox_lookup(sel, chunk);
  end

endmodule

// File: rtl/des_sbox_scheduler.sv
// Time-multiplexes one shared S-box bank over the eight 6-bit chunks of E(R)^K.
// Optional SBOX_SCHED_STATS_EN adds a wrapping done_count handshake counter.
module des_sbox_scheduler
  import des_sbox_scheduler_pkg::*;
#(
  parameter int SBOX_LAT = 0,
  parameter int STATS_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DES_EXP_W-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DES_HALF_W-1:0] out_data,
  output logic [2:0]            sbox_sel,
  output logic [SBOX_IN_W-1:0]  sbox_in,
  input  logic [SBOX_OUT_W-1:0] sbox_out
`ifdef SBOX_SCHED_STATS_EN
  ,
  output logic [STATS_W-1:0]    done_count
`endif
);

  localparam logic       TWO_PHASE = (SBOX_LAT != 0);
  localparam logic [2:0] LAST_IDX  = 3'(SBOX_CNT - 1);

  if (SBOX_LAT < 0 || SBOX_LAT > 1 || STATS_W < 1) begin : g_bad_param
    $error("des_sbox_scheduler: SBOX_LAT must be 0 or 1 and STATS_W at least 1");
  end

  sched_state_e          state_r, state_s;
  logic [2:0]            idx_r, idx_s;
  logic                  phase_r, phase_s;
  logic                  capture_s;
  logic [4:0]            nib_base_s;
  logic [DES_EXP_W-1:0]  data_r, data_s;
  logic                  in_ready_r, in_ready_s;
  logic                  out_valid_r, out_valid_s;
  logic [DES_HALF_W-1:0] out_data_r, out_data_s;
  logic [2:0]            sbox_sel_r, sbox_sel_s;
  logic [SBOX_IN_W-1:0]  sbox_in_r, sbox_in_s;

  // Next-state and next-output logic; every register defaults to holding
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    phase_s     = phase_r;
    data_s      = data_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    sbox_sel_s  = sbox_sel_r;
    sbox_in_s   = sbox_in_r;
    capture_s   = 1'b0;
    nib_base_s  = {LAST_IDX - idx_r, 2'b00};
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          data_s     = in_data;
          idx_s      = 3'd0;
          phase_s    = 1'b0;
          sbox_sel_s = 3'd0;
          sbox_in_s  = chunk_at(in_data, 3'd0);
          in_ready_s = 1'b0;
          state_s    = ST_LOOKUP;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_LOOKUP: begin
        // A registered bank needs an issue cycle before its result can be captured
        capture_s = TWO_PHASE ? phase_r : 1'b1;
        if (capture_s) begin
          out_data_s[nib_base_s +: SBOX_OUT_W] = sbox_out;
          phase_s = 1'b0;
          if (idx_r == LAST_IDX) begin
            out_valid_s = 1'b1;
            state_s     = ST_DONE;
          end else begin
            idx_s      = idx_r + 3'd1;
            sbox_sel_s = idx_r + 3'd1;
            sbox_in_s  = chunk_at(data_r, idx_r + 3'd1);
          end
        end else begin
          phase_s = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        idx_s       = 3'd0;
        phase_s     = 1'b0;
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= 3'd0;
      phase_r     <= 1'b0;
      data_r      <= 48'h0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0;
      sbox_sel_r  <= 3'd0;
      sbox_in_r   <= 6'd0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      phase_r     <= phase_s;
      data_r      <= data_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      sbox_sel_r  <= sbox_sel_s;
      sbox_in_r   <= sbox_in_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign sbox_sel  = sbox_sel_r;
  assign sbox_in   = sbox_in_r;

`ifdef SBOX_SCHED_STATS_EN
  logic [STATS_W-1:0] done_count_r;

  // Completed-handshake counter, wraps naturally at 2^STATS_W
  always_ff @(posedge clk) begin
    if (rst) begin
      done_count_r <= STATS_W'(0);
    end else if (out_valid_r && out_ready) begin
      done_count_r <= done_count_r + STATS_W'(1);
    end else begin
      done_count_r <= done_count_r;
    end
  end

  assign done_count = done_count_r;
`endif

endmodule

// File: tb/tb_des_sbox_scheduler.sv
// Scoreboard bench for des_sbox_scheduler with SBOX_LAT=0 (dut index 0) and
// SBOX_LAT=1 (dut index 1), each driving its own des_sbox_bank.
module tb_des_sbox_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [47:0] in_data   [2];
  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic [31:0] out_data_w  [2];
  logic [2:0]  sel_w  [2];
  logic [5:0]  sin_w  [2];
  logic [3:0]  bank0_out, bank1_out, bank1_out_r;
`ifdef SBOX_SCHED_STATS_EN
  logic [1:0]  done_count_w [2];
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  bit  b2b_on  [2] = '{1'b0, 1'b0};
  int  last_hs [2] = '{-1, -1};

  // Reference DES S-boxes, rows of 16 in order row0..row3
  int sbt [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  des_sbox_scheduler #(.SBOX_LAT(0), .STATS_W(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready_w[0]), .in_data(in_data[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .out_data(out_data_w[0]),
    .sbox_sel(sel_w[0]), .sbox_in(sin_w[0]), .sbox_out(bank0_out)
`ifdef SBOX_SCHED_STATS_EN
    , .done_count(done_count_w[0])
`endif
  );

  des_sbox_scheduler #(.SBOX_LAT(1), .STATS_W(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready_w[1]), .in_data(in_data[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .out_data(out_data_w[1]),
    .sbox_sel(sel_w[1]), .sbox_in(sin_w[1]), .sbox_out(bank1_out_r)
`ifdef SBOX_SCHED_STATS_EN
    , .done_count(done_count_w[1])
`endif
  );

  des_sbox_bank u_bank0 (.sel(sel_w[0]), .chunk(sin_w[0]), .result(bank0_out));
  des_sbox_bank u_bank1 (.sel(sel_w[1]), .chunk(sin_w[1]), .result(bank1_out));

  // One-cycle registered bank for the SBOX_LAT=1 instance
  always_ff @(posedge clk) bank1_out_r <= bank1_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_slayer(input logic [47:0] x);
    logic [47:0] t;
    logic [5:0]  c;
    logic [31:0] r;
    r = 32'h0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      c = t[47:42];
      t = t << 6;
      r = {r[27:0], 4'(sbt[i][{c[5], c[0], c[4:1]}])};
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [47:0] v;
    v[47:16] = $urandom();
    v[15:0]  = 16'($urandom());
    return v;
  endfunction

  task automatic push_exp(input int d, input logic [31:0] v);
    if (d == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Scoreboard: compare every output handshake against the next expected result
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (out_valid_w[d] && out_ready[d]) begin
          if (q_size(d) > 0) begin
            if (d == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            check_eq($sformatf("sb%0d_data", d), out_data_w[d], e);
          end else begin
            check_eq($sformatf("sb%0d_extra_result", d), q_size(d), 1);
          end
          if (b2b_on[d]) begin
            if (last_hs[d] >= 0) check_eq($sformatf("b2b%0d_period", d), cyc - last_hs[d], 8 * (d + 1) + 2);
            last_hs[d] = cyc;
          end
        end
      end
    end
  end

  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready_w[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("ready%0d_timeout", d), in_ready_w[d], 1);
  endtask

  task automatic check_idle_state(input int d, input string tag);
    check_eq({tag, "_in_ready"},  in_ready_w[d],  1);
    check_eq({tag, "_out_valid"}, out_valid_w[d], 0);
    check_eq({tag, "_out_data"},  out_data_w[d],  0);
    check_eq({tag, "_sbox_sel"},  sel_w[d],       0);
    check_eq({tag, "_sbox_in"},   sin_w[d],       0);
  endtask

  // Single transaction with out_ready=1; latency counts the accept cycle itself
  task automatic run_one(input int d, input logic [47:0] data);
    bit ok;
    int lat;
    wait_ready(d, ok);
    if (ok) begin
      in_data[d]  = data;
      in_valid[d] = 1'b1;
      push_exp(d, model_slayer(data));
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
      lat = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid_w[d]) break;
        lat++;
      end
      check_eq($sformatf("latency%0d", d), lat, 8 * (d + 1) + 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_backpressure(input int d);
    bit ok;
    logic [47:0] x;
    logic [31:0] ex;
    x  = rand48();
    ex = model_slayer(x);
    out_ready[d] = 1'b0;
    wait_ready(d, ok);
    in_data[d]  = x;
    in_valid[d] = 1'b1;
    push_exp(d, ex);
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid_w[d]) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp%0d_valid", d), out_valid_w[d], 1);
      check_eq($sformatf("bp%0d_data", d),  out_data_w[d],  ex);
      check_eq($sformatf("bp%0d_ready", d), in_ready_w[d],  0);
      if (i == 5) begin
        in_data[d]  = ~x;
        in_valid[d] = 1'b1;
      end else begin
        in_valid[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1 out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq($sformatf("bp%0d_after_valid", d), out_valid_w[d], 0);
    check_eq($sformatf("bp%0d_after_ready", d), in_ready_w[d],  1);
    repeat (20) @(negedge clk);
    check_eq($sformatf("bp%0d_pulse_ignored", d), out_valid_w[d], 0);
  endtask

  task automatic run_b2b(input int d, input int n);
    bit ok;
    logic [47:0] v;
    b2b_on[d]  = 1'b1;
    last_hs[d] = -1;
    for (int k = 0; k < n; k++) begin
      wait_ready(d, ok);
      if (!ok) break;
      v = rand48();
      in_data[d]  = v;
      in_valid[d] = 1'b1;
      push_exp(d, model_slayer(v));
      @(posedge clk);
    end
    #1 in_valid[d] = 1'b0;
    for (int i = 0; i < 300 && q_size(d) > 0; i++) @(negedge clk);
    check_eq($sformatf("b2b%0d_drained", d), q_size(d), 0);
    @(posedge clk);
    #1 b2b_on[d] = 1'b0;
  endtask

  task automatic run_mid_reset();
    bit ok;
    wait_ready(0, ok);
    in_data[0]  = 48'h0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_partial_seen", out_data_w[0][31:20], 12'hEFA);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    check_idle_state(0, "midrst");
    @(posedge clk);
    #1;
    run_one(0, 48'h0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      in_data[d]   = 48'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_state(0, "reset0");
    check_idle_state(1, "reset1");
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      run_one(d, 48'h0);
      run_one(d, 48'hFFFF_FFFF_FFFF);
      for (int k = 0; k < 3; k++) run_one(d, rand48());
      run_backpressure(d);
      run_b2b(d, 4);
    end
    check_eq("known_zero_model", model_slayer(48'h0), 32'hEFA72C4D);
    check_eq("known_ones_model", model_slayer(48'hFFFF_FFFF_FFFF), 32'hD9CE3DCB);

    run_mid_reset();

`ifdef SBOX_SCHED_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check_eq("stats_reset", done_count_w[0], 0);
    for (int k = 0; k < 5; k++) run_one(0, rand48());
    @(negedge clk);
    check_eq("stats_wrap", done_count_w[0], 2'd1);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
